// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and sizing for the multiply/divide unit
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - command and result bundle between the pipeline and the multiply/divide unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - unsigned one-bit-per-step shift-add multiply / restoring divide datapath
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);
    // acc upper half: partial product or remainder; lower half: multiplier or quotient
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               take;
    logic [2*WIDTH-1:0] acc_next;

    // Next accumulator value for one multiply or divide step
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        take     = shifted >= {1'b0, opnd};
        trial    = shifted - {1'b0, opnd};
        acc_next = acc;
        if (mode) begin
            acc_next = {(take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], take};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

    // Load operands on launch, then advance one step per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, a};
            opnd <= b;
        end else if (step) begin
            acc  <= acc_next;
        end
    end

    assign result = acc;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers; optional MULDIV_DIVZERO_EN
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic     div_zero
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state;
    state_e             state_next;
    logic [CW-1:0]      count;
    logic               iter_load;
    logic               iter_step;
    logic               mode_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [2*WIDTH-1:0] raw;
    logic [2*WIDTH-1:0] fixed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               is_signed;

`ifdef MULDIV_DIVZERO_EN
    logic               dz_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic               div_zero_q;
`endif

    // Signed ops run on magnitudes; the signs are restored in FIN
    assign is_signed = ~bus.op[0];
    assign mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .mode   (iter_load ? bus.op[1] : mode_q),
        .load   (iter_load),
        .step   (iter_step),
        .a      (mag_a),
        .b      (mag_b),
        .result (raw)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and datapath strobes; start is only honoured in IDLE
    always_comb begin
        state_next = state;
        iter_load  = 1'b0;
        iter_step  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.op[2]) begin
                    iter_load  = 1'b1;
                    state_next = RUN;
`ifdef MULDIV_DIVZERO_EN
                    if (bus.op[1] && bus.b == '0) state_next = FIN;
`endif
                end
            end
            RUN: begin
                iter_step = 1'b1;
                if (count == CW'(WIDTH - 1)) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation attributes captured at launch and the step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            mode_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (iter_load) begin
            count    <= '0;
            mode_q   <= bus.op[1];
            neg_lo_q <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi_q <= is_signed & bus.a[WIDTH-1];
        end else if (iter_step) begin
            count    <= count + CW'(1);
        end
    end

`ifdef MULDIV_DIVZERO_EN
    // Divide-by-zero short cut bypasses the datapath, so keep the raw dividend
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_q    <= 1'b0;
            a_raw_q <= '0;
        end else if (iter_load) begin
            dz_q    <= bus.op[1] && bus.b == '0;
            a_raw_q <= bus.a;
        end
    end
`endif

    // Sign correction: whole product for multiply, quotient and remainder separately for divide
    always_comb begin
        fixed = raw;
        if (mode_q) begin
            fixed[2*WIDTH-1:WIDTH] = neg_hi_q ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
            fixed[WIDTH-1:0]       = neg_lo_q ? -raw[WIDTH-1:0]       : raw[WIDTH-1:0];
        end else begin
            fixed = neg_lo_q ? -raw : raw;
        end
`ifdef MULDIV_DIVZERO_EN
        if (dz_q) fixed = {a_raw_q, {WIDTH{1'b1}}};
`endif
    end

    // HI/LO change only on FIN or an IDLE move-to; done marks the FIN write
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == FIN) begin
                hi_q   <= fixed[2*WIDTH-1:WIDTH];
                lo_q   <= fixed[WIDTH-1:0];
                done_q <= 1'b1;
            end else if (state == IDLE && bus.start) begin
                if (bus.op == OP_MTHI) hi_q <= bus.a;
                if (bus.op == OP_MTLO) lo_q <= bus.a;
            end
        end
    end

`ifdef MULDIV_DIVZERO_EN
    // Flag accompanies the done pulse of a short-cut divide
    always_ff @(posedge clk) begin
        if (rst) div_zero_q <= 1'b0;
        else     div_zero_q <= (state == FIN) && dz_q;
    end

    assign div_zero = div_zero_q;
`endif

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
